// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Brief    : Splits 32-bit MEM-stage loads/stores into two half-word
//            transfers on a 16-bit asynchronous SRAM; ready low = freeze.
// Revision : 1.0
// ============================================================================
module sram_controller #(
  parameter int MEM_BASE    = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int          c_cnt_w     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int          c_wait_last = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [31:0] c_base      = 32'(MEM_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [31:0]          r_wdata;
  logic                 r_is_write;
  logic                 w_req;
  logic [16:0]          w_idx;
  logic                 w_drive;
  logic [15:0]          w_dq_out;

  assign w_req = wr_en | rd_en;
  // Modulo-2^32 offset; out-of-window addresses simply wrap onto the SRAM.
  assign w_idx = 17'((address - c_base) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    w_drive      = 1'b0;
    w_dq_out     = r_wdata[15:0];
    case (r_state)
      S_IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_next_state = S_LO;
        end
      end
      S_LO: begin
        w_next_state = S_HI;
        w_drive      = r_is_write;
      end
      S_HI: begin
        w_next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        w_drive      = r_is_write;
        w_dq_out     = r_wdata[31:16];
      end
      S_WAIT: begin
        if (r_wait_cnt == c_cnt_w'(c_wait_last)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        ready        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Reset releases the bus in the same cycle rather than at the next edge.
    if (rst) begin
      w_drive = 1'b0;
    end
  end

  assign SRAM_WE_N = ~w_drive;
  assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // SRAM_ADDR is loaded on the edge that enters LO/HI so address, data and
  // strobe all change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      read_data  <= '0;
      SRAM_ADDR  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wdata    <= write_data;
            r_is_write <= wr_en;
            SRAM_ADDR  <= {w_idx, 1'b0};
            r_wait_cnt <= '0;
          end
        end
        S_LO: begin
          if (!r_is_write) begin
            read_data[15:0] <= SRAM_DQ;
          end
          SRAM_ADDR <= {SRAM_ADDR[17:1], 1'b1};
        end
        S_HI: begin
          if (!r_is_write) begin
            read_data[31:16] <= SRAM_DQ;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Brief    : Self-checking bench for sram_controller with an async SRAM model
//            and a word-level reference memory.
// Revision : 1.0
// ============================================================================
module tb_sram_controller;

  localparam int MEM_BASE    = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int c_len       = 4 + WAIT_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_we_n;
  logic        sram_ce_n;
  logic        sram_oe_n;

  sram_controller #(
    .MEM_BASE    (MEM_BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  always #10 clk = ~clk;

  // Board SRAM: unwritten half-words read back as (address ^ 0x5A5A).
  bit   [15:0] sram_mem [0:262143];
  bit          sram_wr  [0:262143];
  logic [15:0] sram_out;

  always_comb begin
    sram_out = sram_wr[sram_addr] ? sram_mem[sram_addr] : (sram_addr[15:0] ^ 16'h5A5A);
  end

  assign sram_dq = sram_we_n ? sram_out : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) begin
      sram_mem[sram_addr] <= sram_dq;
      sram_wr[sram_addr]  <= 1'b1;
    end
  end

  // Word-level reference model.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rdata;
  logic [17:0] ref_addr;

  int n_checks = 0;
  int n_errors = 0;

  function automatic int unsigned word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(MEM_BASE);
    return (off >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned i);
    logic [15:0] lo_h;
    logic [15:0] hi_h;
    if (ref_mem.exists(i)) return ref_mem[i];
    lo_h = 16'(2 * i) ^ 16'h5A5A;
    hi_h = 16'(2 * i + 1) ^ 16'h5A5A;
    return {hi_h, lo_h};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One complete access starting in the current cycle (c1), checked every cycle.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] wd, input bit drop);
    int unsigned i;
    bit          is_wr;
    logic [31:0] exp_word;
    i        = word_idx(a);
    is_wr    = wr;
    exp_word = is_wr ? wd : ref_word(i);
    wr_en      = wr;
    rd_en      = rd;
    address    = a;
    write_data = wd;
    for (int k = 1; k <= c_len; k++) begin
      @(negedge clk);
      check($sformatf("ready_c%0d", k), 32'(ready), 32'(k == c_len));
      check($sformatf("we_n_c%0d", k), 32'(sram_we_n), 32'(!(is_wr && (k == 2 || k == 3))));
      if (k == 1)      check("addr_c1", 32'(sram_addr), 32'(ref_addr));
      else if (k == 2) check("addr_lo", 32'(sram_addr), 2 * i);
      else             check($sformatf("addr_c%0d", k), 32'(sram_addr), 2 * i + 1);
      if (is_wr && k == 2) check("dq_lo", 32'(sram_dq), 32'(wd[15:0]));
      if (is_wr && k == 3) check("dq_hi", 32'(sram_dq), 32'(wd[31:16]));
      if (!is_wr && k >= 4) check($sformatf("rdata_c%0d", k), read_data, exp_word);
      if (is_wr && k == c_len) check("rdata_kept", read_data, ref_rdata);
      if (k == c_len) check("sram_hi_content", 32'(sram_dq), 32'(exp_word[31:16]));
      @(posedge clk);
      #1;
      if (k == 1 && drop) begin
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = $urandom;
        write_data = $urandom;
      end
    end
    if (is_wr) ref_mem[i] = wd;
    else       ref_rdata  = exp_word;
    ref_addr = 18'(2 * i + 1);
  endtask

  task automatic idle_cycles(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("ready_idle", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] old_word;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wr: 1'b1, rd: 1'b0, addr: 32'd1028, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
    vecs[1] = '{wr: 1'b0, rd: 1'b1, addr: 32'd1028, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'd1024, wdata: 32'h12345678, exp_rdata: 32'hDEADBEEF};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'd1024, wdata: 32'h0,        exp_rdata: 32'h12345678};
    vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 32'd1032, wdata: 32'h0A0B0C0D, exp_rdata: 32'h12345678};
    vecs[5] = '{wr: 1'b0, rd: 1'b1, addr: 32'd1032, wdata: 32'h0,        exp_rdata: 32'h0A0B0C0D};

    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;
    ref_rdata  = '0;
    ref_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_rdata", read_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_released", 32'(sram_dq), 32'h5A5A);
    check("rst_static_pins", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors, issued back to back.
    for (int v = 0; v < 6; v++) begin
      do_access(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata, 1'b0);
      check($sformatf("vec%0d_rdata", v), read_data, vecs[v].exp_rdata);
    end
    idle_cycles(2);
    check("sram_hw0", 32'(sram_mem[0]), 32'h5678);
    check("sram_hw1", 32'(sram_mem[1]), 32'h1234);
    check("sram_hw2", 32'(sram_mem[2]), 32'hBEEF);
    check("sram_hw3", 32'(sram_mem[3]), 32'hDEAD);

    // Reset asserted while the high half of a write is on the bus.
    old_word   = ref_word(4);
    wr_en      = 1'b1;
    rd_en      = 1'b0;
    address    = 32'd1040;
    write_data = 32'hCAFEF00D;
    @(negedge clk);
    check("mid_c1_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_lo_we_n", 32'(sram_we_n), 32'd0);
    check("mid_lo_dq", 32'(sram_dq), 32'hF00D);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    check("mid_hi_we_n_released", 32'(sram_we_n), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_we_n", 32'(sram_we_n), 32'd1);
    check("post_rst_rdata", read_data, 32'd0);
    check("post_rst_addr", 32'(sram_addr), 32'd0);
    check("post_rst_dq_released", 32'(sram_dq), 32'h5678);
    @(posedge clk);
    #1;
    ref_mem[4] = {old_word[31:16], 16'hF00D};
    ref_rdata  = '0;
    ref_addr   = '0;
    do_access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
    check("partial_word_read", read_data, {old_word[31:16], 16'hF00D});

    // Randomized traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(MEM_BASE) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      do_access(op != 1, op != 0, a, $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences 32-bit data-memory reads and writes from the ARM pipeline's MEM stage onto the board's 16-bit asynchronous SRAM. Each access is split into two half-word transfers. The controller holds `ready` low until the access completes; the pipeline uses `~ready` as a global freeze for PC, all stage registers and the hazard path. It replaces the on-chip data memory inside the MEM stage and is instantiated at the top level with its SRAM pins wired straight to the board SRAM port.

## Interface
Parameters:
- `MEM_BASE`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 2: idle cycles inserted after the two half-word transfers; minimum 0.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  MEM-stage store request (MEM_W_EN).
- `rd_en`  in  1  MEM-stage load request (MEM_R_EN).
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  access complete / no access pending; freeze = ~ready.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  byte masks; always 0.
- `SRAM_WE_N`  out  1  write strobe, active-low.
- `SRAM_CE_N`  out  1  chip enable; always 0.
- `SRAM_OE_N`  out  1  output enable; always 0.

## Operation
- Word index `idx = ((address - MEM_BASE) >> 2)[16:0]`. The subtraction is 32-bit modulo, so out-of-range addresses wrap and are not flagged.
- Half-word address mapping:
  - Low half: `SRAM_ADDR = {idx,1'b0}`.
  - High half: `SRAM_ADDR = {idx,1'b1}`.
- Request arbitration:
  - `wr_en` and `rd_en` both high is treated as a write.
  - A request is accepted only in IDLE. `address`, `write_data` and the operation are latched on the IDLE→LO edge.
- State machine:
  - IDLE → LO when a request is present; otherwise stay in IDLE.
  - LO → HI: transfer low half.
  - HI → WAIT (or DONE if `WAIT_CYCLES = 0`): transfer high half.
  - WAIT: counts `WAIT_CYCLES` cycles, then → DONE.
  - DONE → IDLE unconditionally.
- Write:
  - In LO: `SRAM_WE_N = 0`, `SRAM_DQ = wd[15:0]`.
  - In HI: `SRAM_WE_N = 0`, `SRAM_DQ = wd[31:16]`.
  - In all other states `SRAM_DQ` is high-Z.
- Read:
  - `SRAM_WE_N = 1` and `SRAM_DQ` is high-Z.
  - `read_data[15:0]` captures `SRAM_DQ` at the end of LO.
  - `read_data[31:16]` captures `SRAM_DQ` at the end of HI.
  - Writes leave `read_data` unchanged.
- `ready` is combinational:
  - 1 in IDLE with no request.
  - 0 in IDLE with a request.
  - 0 in LO, HI and WAIT.
  - 1 in DONE.
- Outside LO and HI, `SRAM_ADDR` holds the last driven value; after reset it is 0.
- Reset values:
  - State IDLE, wait counter 0, `read_data = 0`, `SRAM_ADDR = 0`.
  - `SRAM_WE_N = 1`, `SRAM_DQ` high-Z.
  - `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` all 0.
  - `ready = 1` (with no request present).
- Reset mid-access: return to IDLE on the next edge and release WE_N and DQ immediately that cycle. A partially written word is left as-is.

## Timing
- With `WAIT_CYCLES = 2`, a request first seen in cycle 1 runs: IDLE (c1), LO (c2), HI (c3), WAIT (c4, c5), DONE (c6).
- `ready = 1` in c6, so the pipeline advances on the c6→c7 edge. Total access is `4 + WAIT_CYCLES` cycles.
- `read_data` is valid from the start of c4 and is stable through DONE.
- WE_N, ADDR and DQ are driven in the same cycle the state is entered, so address, data and strobe switch together. WE_N is low for one full cycle (20 ns) per half, which meets the SRAM tWP.
- Back-to-back requests: the request in the cycle after DONE is seen in IDLE. Consecutive accesses are therefore spaced `4 + WAIT_CYCLES` cycles apart with no dead cycle besides IDLE.
- Request deasserted mid-access: ignored; the latched operation completes.

## Test plan
- After reset, no request → `ready = 1`, `SRAM_WE_N = 1`, `SRAM_DQ = Z`, `read_data = 0`, `SRAM_ADDR = 0`.
- Write `address = 1028`, `write_data = 0xDEADBEEF`:
  - c2: `SRAM_ADDR = 2`, `DQ = 0xBEEF`, `WE_N = 0`.
  - c3: `SRAM_ADDR = 3`, `DQ = 0xDEAD`, `WE_N = 0`.
  - `ready = 0` in c1–c5 and 1 in c6.
- Read `address = 1028` after that write → `read_data = 0xDEADBEEF` by c4, `ready = 1` in c6, `WE_N` stays 1 throughout.
- `rd_en` and `wr_en` both high, `address = 1024`, `write_data = 0x12345678` → write performed; SRAM model holds `0x5678` at half-word 0 and `0x1234` at half-word 1.
- Back-to-back write then read to `address = 1032` → second access starts in IDLE the cycle after the first DONE and returns the written value.
- `rst` asserted during HI of a write → next cycle IDLE, `WE_N = 1`, `DQ = Z`, `read_data = 0`; a subsequent read completes normally.
